// File: rtl/reg_read_fsm.sv
`default_nettype none
// ============================================================================
// Module   : reg_read_fsm
// Brief    : Register-read micro-op. Drives one register enable onto the
//            shared bus for a settle window, captures the bus, pulses done.
// Revision : 1.0 - initial release
// ============================================================================
module reg_read_fsm #(
    parameter int WIDTH  = 16,
    parameter int SETTLE = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             donefetch,
    input  logic [5:0]       parameter1,
    input  logic [WIDTH-1:0] bus_in,
    output logic             r0out,
    output logic             r1out,
    output logic             r2out,
    output logic             r3out,
    output logic             P0out,
    output logic [WIDTH-1:0] data_out,
    output logic             valid,
    output logic             busy,
    output logic             done,
    output logic             err
);

    localparam logic [3:0] c_SETTLE_LAST = 4'(SETTLE - 1);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_DECODE  = 3'd1,
        S_DRIVE   = 3'd2,
        S_CAPTURE = 3'd3,
        S_DONE    = 3'd4,
        S_ERR     = 3'd5,
        S_WAITREL = 3'd6
    } state_t;

    state_t           r_state;
    logic [5:0]       r_sel;
    logic [3:0]       r_cnt;
    logic [4:0]       r_en;
    logic [WIDTH-1:0] r_data;
    logic             r_valid;
    logic             r_busy;
    logic             r_done;
    logic             r_err;

    // Enable vector bit order: {P0, r3, r2, r1, r0}
    function automatic logic [4:0] sel_onehot(input logic [5:0] s);
        logic [4:0] oh;
        oh = 5'b00000;
        case (s)
            6'd0:    oh = 5'b00001;
            6'd1:    oh = 5'b00010;
            6'd2:    oh = 5'b00100;
            6'd3:    oh = 5'b01000;
            6'd4:    oh = 5'b10000;
            default: oh = 5'b00000;
        endcase
        return oh;
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_sel   <= 6'd0;
            r_cnt   <= 4'd0;
            r_en    <= 5'b00000;
            r_data  <= '0;
            r_valid <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_err   <= 1'b0;
        end else if (donefetch && (r_state != S_IDLE)) begin
            // Abort drops the bus immediately; captured data is preserved
            r_state <= S_IDLE;
            r_en    <= 5'b00000;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start && !donefetch) begin
                        r_state <= S_DECODE;
                        r_sel   <= parameter1;
                        r_busy  <= 1'b1;
                    end
                end
                S_DECODE: begin
                    if (r_sel <= 6'd4) begin
                        r_state <= S_DRIVE;
                        r_cnt   <= 4'd0;
                        r_en    <= sel_onehot(r_sel);
                    end else begin
                        r_state <= S_ERR;
                        r_err   <= 1'b1;
                        r_done  <= 1'b1;
                    end
                end
                S_DRIVE: begin
                    r_cnt <= r_cnt + 4'd1;
                    if (r_cnt == c_SETTLE_LAST) begin
                        r_state <= S_CAPTURE;
                    end
                end
                S_CAPTURE: begin
                    r_state <= S_DONE;
                    r_data  <= bus_in;
                    r_valid <= 1'b1;
                    r_en    <= 5'b00000;
                    r_done  <= 1'b1;
                end
                S_DONE: begin
                    r_state <= S_WAITREL;
                    r_done  <= 1'b0;
                end
                S_ERR: begin
                    r_state <= S_WAITREL;
                    r_done  <= 1'b0;
                    r_err   <= 1'b0;
                end
                S_WAITREL: begin
                    // A held start parks here so it cannot retrigger
                    if (!start) begin
                        r_state <= S_IDLE;
                        r_busy  <= 1'b0;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_en    <= 5'b00000;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                    r_err   <= 1'b0;
                end
            endcase
        end
    end

    assign r0out    = r_en[0];
    assign r1out    = r_en[1];
    assign r2out    = r_en[2];
    assign r3out    = r_en[3];
    assign P0out    = r_en[4];
    assign data_out = r_data;
    assign valid    = r_valid;
    assign busy     = r_busy;
    assign done     = r_done;
    assign err      = r_err;

endmodule
`default_nettype wire

// File: tb/tb_reg_read_fsm.sv
`default_nettype none
// ============================================================================
// Module   : tb_reg_read_fsm
// Brief    : Directed self-checking bench for reg_read_fsm (SETTLE=2).
// Revision : 1.0 - initial release
// ============================================================================
module tb_reg_read_fsm;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        donefetch;
    logic [5:0]  parameter1;
    logic [15:0] bus_in;
    logic        r0out, r1out, r2out, r3out, P0out;
    logic [15:0] data_out;
    logic        valid, busy, done, err;

    int errors = 0;
    int checks = 0;
    int en_cnt;
    int done_cnt;

    reg_read_fsm #(.WIDTH(16), .SETTLE(2)) u_dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .donefetch  (donefetch),
        .parameter1 (parameter1),
        .bus_in     (bus_in),
        .r0out      (r0out),
        .r1out      (r1out),
        .r2out      (r2out),
        .r3out      (r3out),
        .P0out      (P0out),
        .data_out   (data_out),
        .valid      (valid),
        .busy       (busy),
        .done       (done),
        .err        (err)
    );

    always #5 clk = ~clk;

    wire [4:0] w_en = {P0out, r3out, r2out, r1out, r0out};

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Checks {en, busy, done, err} in one comparison
    task automatic chk_ctl(input string tag, input logic [4:0] en, input logic b,
                           input logic d, input logic e);
        chk(tag, {24'd0, w_en, busy, done, err}, {24'd0, en, b, d, e});
    endtask

    initial begin
        rst = 1'b1; start = 1'b1; donefetch = 1'b0; parameter1 = 6'd0; bus_in = 16'h0000;

        // Reset held two cycles with start high
        tick(); tick();
        chk_ctl("reset_ctl", 5'b00000, 1'b0, 1'b0, 1'b0);
        chk("reset_data", {15'd0, valid, data_out}, 32'd0);
        rst = 1'b0; start = 1'b0;
        tick(); tick();
        chk_ctl("idle_after_reset", 5'b00000, 1'b0, 1'b0, 1'b0);

        // Read r2, one-cycle start pulse
        start = 1'b1; parameter1 = 6'd2; bus_in = 16'hA5C3;
        tick();                                   // DECODE
        start = 1'b0;
        chk_ctl("r2_decode", 5'b00000, 1'b1, 1'b0, 1'b0);
        tick(); chk_ctl("r2_drive0",  5'b00100, 1'b1, 1'b0, 1'b0);
        tick(); chk_ctl("r2_drive1",  5'b00100, 1'b1, 1'b0, 1'b0);
        tick(); chk_ctl("r2_capture", 5'b00100, 1'b1, 1'b0, 1'b0);
        chk("r2_no_early_valid", {31'd0, valid}, 32'd0);
        tick(); chk_ctl("r2_done", 5'b00000, 1'b1, 1'b1, 1'b0);
        chk("r2_data", {15'd0, valid, data_out}, {15'd0, 1'b1, 16'hA5C3});
        tick(); chk_ctl("r2_waitrel", 5'b00000, 1'b1, 1'b0, 1'b0);
        tick(); chk_ctl("r2_idle", 5'b00000, 1'b0, 1'b0, 1'b0);

        // Illegal select
        start = 1'b1; parameter1 = 6'b000111; bus_in = 16'hFFFF;
        tick();
        start = 1'b0;
        chk_ctl("ill_decode", 5'b00000, 1'b1, 1'b0, 1'b0);
        tick(); chk_ctl("ill_err", 5'b00000, 1'b1, 1'b1, 1'b1);
        tick(); chk_ctl("ill_waitrel", 5'b00000, 1'b1, 1'b0, 1'b0);
        tick(); chk_ctl("ill_idle", 5'b00000, 1'b0, 1'b0, 1'b0);
        chk("ill_data_kept", {15'd0, valid, data_out}, {15'd0, 1'b1, 16'hA5C3});

        // Read P0 with start held for 10 cycles; parameter1 changes after the start edge
        start = 1'b1; parameter1 = 6'd4; bus_in = 16'h0F0F;
        en_cnt = 0; done_cnt = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            parameter1 = 6'd0;
            if (w_en == 5'b10000) en_cnt++;
            if (done) done_cnt++;
        end
        chk("p0_enable_cycles", en_cnt, 3);
        chk("p0_done_count", done_cnt, 1);
        chk("p0_data", {15'd0, valid, data_out}, {15'd0, 1'b1, 16'h0F0F});
        chk_ctl("p0_parked", 5'b00000, 1'b1, 1'b0, 1'b0);
        start = 1'b0;
        tick(); chk_ctl("p0_released", 5'b00000, 1'b0, 1'b0, 1'b0);

        // r1 read aborted during second DRIVE cycle
        start = 1'b1; parameter1 = 6'd1; bus_in = 16'h1234;
        tick(); start = 1'b0;                     // DECODE
        tick(); chk_ctl("ab_drive0", 5'b00010, 1'b1, 1'b0, 1'b0);
        tick(); chk_ctl("ab_drive1", 5'b00010, 1'b1, 1'b0, 1'b0);
        donefetch = 1'b1;
        tick(); donefetch = 1'b0;
        chk_ctl("ab_dropped", 5'b00000, 1'b0, 1'b0, 1'b0);
        chk("ab_data_kept", {15'd0, valid, data_out}, {15'd0, 1'b1, 16'h0F0F});
        tick(); chk_ctl("ab_no_done", 5'b00000, 1'b0, 1'b0, 1'b0);

        // donefetch with start in IDLE stays idle
        start = 1'b1; donefetch = 1'b1;
        tick(); start = 1'b0; donefetch = 1'b0;
        chk_ctl("df_idle", 5'b00000, 1'b0, 1'b0, 1'b0);

        // Full r1 read after the abort
        start = 1'b1; parameter1 = 6'd1;
        tick(); start = 1'b0;
        tick(); tick(); tick();
        chk_ctl("r1_capture", 5'b00010, 1'b1, 1'b0, 1'b0);
        tick(); chk_ctl("r1_done", 5'b00000, 1'b1, 1'b1, 1'b0);
        chk("r1_data", {15'd0, valid, data_out}, {15'd0, 1'b1, 16'h1234});
        tick(); tick();

        // rst during CAPTURE of an r3 read
        start = 1'b1; parameter1 = 6'd3; bus_in = 16'hBEEF;
        tick(); start = 1'b0;
        tick(); tick(); tick();
        chk_ctl("r3_capture", 5'b01000, 1'b1, 1'b0, 1'b0);
        rst = 1'b1;
        tick(); rst = 1'b0;
        chk_ctl("r3_rst_ctl", 5'b00000, 1'b0, 1'b0, 1'b0);
        chk("r3_rst_data", {15'd0, valid, data_out}, 32'd0);
        tick(); chk_ctl("r3_rst_idle", 5'b00000, 1'b0, 1'b0, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/reg_read_fsm.md
Name: reg_read_fsm

Overview:
- Reader-side companion to the immediate-move controller: executes a register-read micro-op.
- Drives the output enable of one selected register (r0..r3, P0) onto the shared 16-bit bus and holds it for a settle window.
- Captures the bus value into a holding register and signals done to the instruction sequencer.
- Sits beside the other per-opcode FSMs; it is started by the sequencer and aborted by donefetch.

Parameters:
WIDTH, 16, bus and capture data width
SETTLE, 2, number of cycles the register output is driven before the capture cycle (legal range 1..15)

Ports:
clk  input  1  system clock, all state changes on rising edge
rst  input  1  synchronous active-high reset
start  input  1  level request from sequencer; sampled only in IDLE
donefetch  input  1  synchronous abort; returns FSM to IDLE
parameter1  input  6  source register select: 0=r0, 1=r1, 2=r2, 3=r3, 4=P0, others illegal
bus_in  input  WIDTH  shared data bus
r0out,r1out,r2out,r3out,P0out  output  1 each  register tri-state output enables (one-hot or all zero)
data_out  output  WIDTH  captured bus value
valid  output  1  data_out holds a value from a completed read
busy  output  1  FSM not in IDLE
done  output  1  one-cycle completion pulse
err  output  1  one-cycle pulse on illegal select

Behaviour:
- Priority on each rising edge: rst, then donefetch, then normal transitions.
- Reset values:
  - state=IDLE; all rXout/P0out=0; done=0; err=0; busy=0.
  - valid=0; data_out=0; internal counter=0; latched select=0.
- All outputs are registered or decoded from registered state only; no output depends combinationally on start or bus_in.
- States:
  - IDLE:
    - start=1 and donefetch=0 -> DECODE.
    - Latch parameter1 into sel_q on the same edge.
    - parameter1 is ignored after this edge.
  - DECODE:
    - sel_q<=4 -> DRIVE, counter cleared.
    - sel_q>4 -> ERR.
  - DRIVE:
    - Enable selected by sel_q is 1; all others 0.
    - Counter increments each cycle; when counter==SETTLE-1 -> CAPTURE.
  - CAPTURE:
    - Same enable held.
    - On the exit edge, data_out<=bus_in and valid<=1 -> DONE.
  - DONE: done=1 and enables 0 for exactly one cycle -> WAITREL.
  - ERR:
    - err=1 and done=1 for one cycle; no enable ever asserted.
    - data_out and valid unchanged -> WAITREL.
  - WAITREL: stay while start=1; start=0 -> IDLE. A held start therefore never retriggers.
- busy=1 in every state except IDLE.
- Enable timing: the enable is high for SETTLE+1 consecutive cycles (DRIVE + CAPTURE) and is never asserted in DECODE/DONE/ERR/WAITREL.
- Latency, with edge E0 sampling start:
  - Enable rises after E0+1.
  - Capture occurs on edge E0+SETTLE+2.
  - done is high in the cycle following that edge.
- donefetch in any non-IDLE state:
  - Next state IDLE; all enables 0 on the following cycle.
  - No capture occurs; done and err are not pulsed.
  - data_out/valid keep their previous values.
- donefetch together with start in IDLE: stay IDLE.
- rst mid-operation: all outputs return to reset values on that edge, including valid=0 and data_out=0.
- data_out is only written in CAPTURE and holds until the next successful capture or reset.

Test Plan:
- Reset:
  - Assert rst 2 cycles with start=1 -> all outputs 0, busy=0.
  - Release with start=0 -> stays IDLE.
- Read r2 with SETTLE=2, parameter1=2, bus_in=16'hA5C3, 1-cycle start pulse:
  - r2out=1 for exactly 3 cycles starting 2 cycles after the start edge; other enables 0.
  - data_out=16'hA5C3, valid=1, done 1-cycle pulse on the 5th cycle.
- Read P0 (parameter1=4, bus_in=16'h0F0F) with start held high 10 cycles:
  - P0out pulse once, single done, data_out=16'h0F0F.
  - FSM parks in WAITREL (busy=1) until start drops, then IDLE.
- Illegal select parameter1=6'b000111:
  - err=1 and done=1 together for 1 cycle, no enable ever high.
  - data_out keeps 16'hA5C3 from the prior read.
- Abort: donefetch asserted during second DRIVE cycle of an r1 read with bus_in=16'h1234:
  - r1out drops next cycle, no done.
  - data_out unchanged; next start performs a full normal read.
- rst during CAPTURE of an r3 read -> valid=0, data_out=0, r3out=0 on the following cycle; FSM in IDLE.
